// File: rtl/tricolor_led_driver.sv
// Tricolor LED driver: PWM-dims one colour at a time, cross-fading on colour changes.
// Latency: LED drives are registered, one cycle after pwm_cnt/duty/color_q.
// Backpressure: none; load is always accepted, and a load during a fade retargets it.
//
// Ports:
//   clk, rst                   single clock, synchronous active-high reset
//   red_in, green_in, blue_in  requested colour flags, sampled on load
//   load                       single-cycle strobe capturing colour flags and level
//   level [PWM_W]              target brightness (0 = off, all ones = maximum)
//   led_r, led_g, led_b        registered PWM drives
//   busy                       high while a fade is in progress
//   color_q [3]                displayed colour {r,g,b}
//
// Optional feature: define TRICOLOR_DRV_BLINK_EN to blink all LEDs while blue is displayed.
module tricolor_led_driver #(
    parameter int PWM_W     = 4,
    parameter int FADE_STEP = 16,
    parameter int BLINK_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             red_in,
    input  logic             green_in,
    input  logic             blue_in,
    input  logic             load,
    input  logic [PWM_W-1:0] level,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             busy,
    output logic [2:0]       color_q
);

    localparam int STEP_W = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FADE_STEP - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [PWM_W-1:0]  duty, duty_nxt;
    logic [PWM_W-1:0]  tgt_level, tgt_nxt;
    logic [STEP_W-1:0] step_cnt, step_nxt;
    logic [2:0]        pend_color, pend_nxt;
    logic [2:0]        color_nxt;
    logic [2:0]        in_color;
    logic              step_end;
    logic [STEP_W-1:0] step_inc;
    logic              pwm_on;
    logic              blink_gate;

    assign in_color = {red_in, green_in, blue_in};
    assign step_end = (step_cnt == STEP_LAST);
    assign step_inc = step_end ? '0 : step_cnt + 1'b1;
    assign pwm_on   = (pwm_cnt < duty);
    assign busy     = (state != IDLE);

    // Next-state and datapath updates for the fade sequencer.
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        step_nxt  = step_cnt;
        color_nxt = color_q;
        pend_nxt  = pend_color;
        tgt_nxt   = tgt_level;

        case (state)
            IDLE: begin
                step_nxt = '0;
                if (load) begin
                    if (in_color == color_q) begin
                        // Same colour: brightness change only, applied immediately.
                        duty_nxt = level;
                    end else begin
                        pend_nxt  = in_color;
                        tgt_nxt   = level;
                        state_nxt = FADE_OUT;
                    end
                end
            end

            FADE_OUT: begin
                step_nxt = step_inc;
                // Last load wins; the fade-out itself keeps its progress.
                if (load) begin
                    pend_nxt = in_color;
                    tgt_nxt  = level;
                end
                // Zero check runs every cycle, so entering at duty 0 swaps at once.
                if (duty == '0) begin
                    color_nxt = pend_nxt;
                    step_nxt  = '0;
                    state_nxt = FADE_IN;
                end else if (step_end) begin
                    duty_nxt = duty - 1'b1;
                end
            end

            FADE_IN: begin
                step_nxt = step_inc;
                if (load && (in_color != color_q)) begin
                    // Colour changed again: fade out from wherever duty is now.
                    pend_nxt  = in_color;
                    tgt_nxt   = level;
                    step_nxt  = '0;
                    state_nxt = FADE_OUT;
                end else begin
                    if (load) begin
                        tgt_nxt = level;
                    end
                    // Compare against the freshest target so a lowered level
                    // clamps duty instead of overshooting it.
                    if (duty >= tgt_nxt) begin
                        duty_nxt  = tgt_nxt;
                        state_nxt = IDLE;
                    end else if (step_end) begin
                        duty_nxt = duty + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            duty       <= '0;
            step_cnt   <= '0;
            color_q    <= '0;
            pend_color <= '0;
            tgt_level  <= '0;
        end else begin
            state      <= state_nxt;
            duty       <= duty_nxt;
            step_cnt   <= step_nxt;
            color_q    <= color_nxt;
            pend_color <= pend_nxt;
            tgt_level  <= tgt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

`ifdef TRICOLOR_DRV_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Blue blinks: LEDs on for the lower half of the blink period only.
    assign blink_gate = ~color_q[0] | ~blink_cnt[BLINK_W-1];
`else
    // Blink disabled; the expression is constant true for any legal width.
    assign blink_gate = (BLINK_W > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
        end else begin
            led_r <= color_q[2] & pwm_on & blink_gate;
            led_g <= color_q[1] & pwm_on & blink_gate;
            led_b <= color_q[0] & pwm_on & blink_gate;
        end
    end

endmodule

// File: doc/tricolor_led_driver.md
TRICOLOR_LED_DRIVER -- requirements
Module: tricolor_led_driver

Interface
REQ-001 SHALL have parameter PWM_W, default 4, meaning PWM counter and duty width in bits.
REQ-002 SHALL have parameter FADE_STEP, default 16, meaning clock cycles per one-LSB duty change during a fade (minimum 1).
REQ-003 SHALL have parameter BLINK_W, default 8, meaning blink counter width in bits (used only when TRICOLOR_DRV_BLINK_EN is defined).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 red_in, green_in, blue_in  input  1 each  colour flags from the upstream tricolor comparator.
REQ-007 load  input  1  single-cycle strobe; samples the colour flags and level.
REQ-008 level  input  PWM_W  target brightness; 0 = off, 2^PWM_W-1 = maximum.
REQ-009 led_r, led_g, led_b  output  1 each  registered PWM LED drives.
REQ-010 busy  output  1  high while a fade is in progress (state != IDLE).
REQ-011 color_q  output  3  currently displayed colour {r,g,b}.

Function
REQ-012 pwm_cnt (PWM_W bits) SHALL increment every cycle and wrap from 2^PWM_W-1 to 0.
REQ-013 led_x SHALL be registered: it equals color_q[x] & (pwm_cnt < duty), sampled on the previous edge (one-cycle latency).
REQ-014 The FSM SHALL have three states: IDLE, FADE_OUT and FADE_IN.
REQ-015 IDLE, load with {r,g,b} == color_q: duty SHALL take the value of level on the next edge, with no fade, and busy SHALL stay 0.
REQ-016 IDLE, load with {r,g,b} != color_q: the block SHALL capture pend_color and tgt_level, clear step_cnt, and enter FADE_OUT.
REQ-017 step_cnt SHALL count 0..FADE_STEP-1 in either fade state; a step boundary occurs when step_cnt == FADE_STEP-1.
REQ-018 FADE_OUT, at each step boundary: if duty > 0, duty SHALL decrement by 1.
REQ-019 FADE_OUT, when duty == 0 (checked every cycle, including on entry): color_q SHALL load pend_color, step_cnt SHALL clear, and the FSM SHALL enter FADE_IN.
REQ-020 FADE_IN, at each step boundary: if duty < tgt_level, duty SHALL increment by 1.
REQ-021 FADE_IN, when duty >= tgt_level (checked every cycle): duty SHALL take tgt_level and the FSM SHALL return to IDLE.
REQ-022 A load while in FADE_OUT SHALL overwrite pend_color and tgt_level (last wins); the fade continues without restarting.
REQ-023 A load while in FADE_IN with a new colour != color_q SHALL capture pend_color and tgt_level and enter FADE_OUT from the current duty.
REQ-024 A load while in FADE_IN with the same colour SHALL update tgt_level only.
REQ-025 duty SHALL never wrap: it saturates at 0 and at tgt_level.

Reset
REQ-026 While rst is high, the following SHALL be 0 on the next edge: state (IDLE), pwm_cnt, duty, step_cnt, color_q, pend_color, tgt_level, all led outputs, busy and the blink counter.
REQ-027 Reset mid-fade SHALL abort the fade; a load asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-028 With TRICOLOR_DRV_BLINK_EN defined: a free-running BLINK_W-bit blink_cnt SHALL exist.
REQ-029 With TRICOLOR_DRV_BLINK_EN defined and color_q[0] (blue) == 1: all three led outputs SHALL additionally be gated by ~blink_cnt[BLINK_W-1], so the LEDs are on during the first half-period after the counter is 0.
REQ-030 Without TRICOLOR_DRV_BLINK_EN: no blink counter SHALL exist, no gating SHALL be applied, and BLINK_W SHALL be ignored.

Verification (PWM_W=4, FADE_STEP=2)
REQ-031 Scenario: hold rst high for 3 cycles -> led_r/g/b = 0, busy = 0, color_q = 000, duty = 0.
REQ-032 Scenario: from reset, load rgb=100 with level=8 -> busy = 1; color_q = 100 one cycle after entering FADE_OUT; duty reaches 8 after 16 cycles; busy = 0; led_r then high for 8 of every 16 cycles.
REQ-033 Scenario: steady at 100/level 8, load rgb=100 with level=15 -> duty = 15 next cycle; busy stays 0; led_r high for 15 of every 16 cycles.
REQ-034 Scenario: steady at 100/level 8, load rgb=010 with level=4 -> duty falls 8 to 0 over 16 cycles; color_q changes to 010; duty rises to 4 over 8 cycles; led_r never high after the swap.
REQ-035 Scenario: load rgb=001 during FADE_IN at duty 3 -> the FSM enters FADE_OUT next cycle and duty decrements from 3.
REQ-036 Scenario: with TRICOLOR_DRV_BLINK_EN and BLINK_W=3, color 001 at level 15 -> led_b follows the PWM pattern for 4 cycles, then is 0 for 4 cycles, repeating.
